// File: rtl/key_edge_pio_if.sv
// Avalon-MM slave bus bundle for the key/switch input port.
// The host side drives the master modport; key_edge_pio uses slave.
interface key_edge_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/key_edge_pio.sv
// Push-button/switch input port: two-flop synchroniser, per-bit debounce,
// edge-capture register with write-1-to-clear and a maskable level irq.
module key_edge_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  key_edge_pio_if.slave    bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_DIR  = 2'd1,
    REG_MASK = 2'd2,
    REG_EDGE = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  reg_addr_e        addr_sel;

  assign addr_sel = reg_addr_e'(bus.address);
  assign wr_en    = bus.chipselect & ~bus.write_n;

  // Writedata bits above WIDTH carry no meaning for this port.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:WIDTH];
  end

  // Debounce: a bit is accepted only after DEBOUNCE_CYCLES consecutive
  // mismatches; any match in between restarts the count from zero.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the loop can leave a value unassigned and infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = ~stable_q &  stable_d;
  assign fall =  stable_q & ~stable_d;

  if (EDGE_TYPE == 0) begin : g_edge_rise
    assign set_bits = rise;
  end else if (EDGE_TYPE == 1) begin : g_edge_fall
    assign set_bits = fall;
  end else begin : g_edge_any
    assign set_bits = rise | fall;
  end

  assign clr_bits = (wr_en && addr_sel == REG_EDGE) ? bus.writedata[WIDTH-1:0]
                                                     : '0;

  // A capture arriving in the same cycle as its clear must not be lost.
  assign edge_d = (edge_q & ~clr_bits) | set_bits;

  // NOTE: all state here uses non-blocking assignment so every flop samples
  // the pre-edge value of the others; sync1 -> sync2 relies on exactly that.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= IDLE_LEVEL;
      sync2    <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      mask_q   <= '0;
      edge_q   <= '0;
      // NOTE: the counter array is reset on purpose: a press interrupted by
      // reset must be re-debounced in full, not resume a stale count.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_q <= stable_d;
      edge_q   <= edge_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (wr_en && addr_sel == REG_MASK) begin
        mask_q <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  // Decoded from flops only, so the request line cannot glitch.
  assign irq = |(edge_q & mask_q);

  // Zero-wait-state read path; reading never alters any register.
  always_comb begin
    bus.readdata = '0;
    case (addr_sel)
      REG_DATA: bus.readdata[WIDTH-1:0] = stable_q;
      REG_MASK: bus.readdata[WIDTH-1:0] = mask_q;
      REG_EDGE: bus.readdata[WIDTH-1:0] = edge_q;
      default:  bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_key_edge_pio.sv
// Self-checking bench for key_edge_pio (WIDTH=4, DEBOUNCE_CYCLES=4, falling
// edges): directed steps from the test plan, then randomized traffic.
module tb_key_edge_pio;

  localparam int DC = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;
  int         n_checks;
  int         n_errors;

  key_edge_pio_if bus ();

  key_edge_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DC),
    .EDGE_TYPE       (1),
    .IDLE_LEVEL      (4'hF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit's accepted level becomes v once the DC input
  // samples taken two or more edges back all differ from the current level.
  logic [3:0] hist [DC+1];
  logic [3:0] m_stable;
  logic [3:0] m_mask;
  logic [3:0] m_ec;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= DC; j++) hist[j] <= 4'hF;
      m_stable <= 4'hF;
      m_mask   <= 4'h0;
      m_ec     <= 4'h0;
    end else begin : mdl_step
      logic [3:0] acc;
      logic [3:0] nxt;
      logic [3:0] clr;
      acc = 4'hF;
      for (int j = 0; j < DC; j++) acc = acc & (hist[j] ^ m_stable);
      nxt = m_stable ^ acc;
      clr = 4'h0;
      if (bus.chipselect && !bus.write_n && bus.address == 2'd3) clr = bus.writedata[3:0];
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask <= bus.writedata[3:0];
      m_ec     <= (m_ec & ~clr) | (m_stable & ~nxt);
      m_stable <= nxt;
      for (int j = 0; j < DC; j++) hist[j] <= hist[j+1];
      hist[DC] <= in_port;
    end
  end

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0:       return {28'h0, m_stable};
      2:       return {28'h0, m_mask};
      3:       return {28'h0, m_ec};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.write_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write_n   = 1'b0;
    tick();
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      check($sformatf("%s_a%0d", tag, a), bus.readdata, model_read(a));
    end
    check($sformatf("%s_irq", tag), 32'(irq), 32'(|(m_ec & m_mask)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset values
    read_chk("rst_data", 2'd0, 32'hF);
    read_chk("rst_dir",  2'd1, 32'h0);
    read_chk("rst_mask", 2'd2, 32'h0);
    read_chk("rst_edge", 2'd3, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Press on bit 0: accepted exactly DC+1 edges after it is sampled
    wr(2'd2, 32'h1);
    read_chk("mask_rd", 2'd2, 32'h1);
    in_port = 4'hE;
    repeat (5) begin
      tick();
      check_regs("press");
    end
    read_chk("press_pre", 2'd0, 32'hF);
    tick();
    read_chk("press_data", 2'd0, 32'hE);
    read_chk("press_edge", 2'd3, 32'h1);
    check("press_irq", 32'(irq), 32'h1);

    // Three-sample glitch on bit 1 is rejected, a longer low is accepted
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (6) begin
      tick();
      check_regs("glitch");
    end
    read_chk("glitch_data", 2'd0, 32'hE);
    read_chk("glitch_edge", 2'd3, 32'h1);
    in_port = 4'hC;
    repeat (6) begin
      tick();
      check_regs("long");
    end
    read_chk("long_data", 2'd0, 32'hC);
    read_chk("long_edge", 2'd3, 32'h3);

    // Write-1-to-clear
    wr(2'd3, 32'h1);
    read_chk("clr0_edge", 2'd3, 32'h2);
    check("clr0_irq", 32'(irq), 32'h0);
    wr(2'd3, 32'hFFFF_FFF2);
    read_chk("clr1_edge", 2'd3, 32'h0);

    // Releases do not capture with falling-edge selection
    in_port = 4'hF;
    repeat (7) begin
      tick();
      check_regs("release");
    end
    read_chk("release_data", 2'd0, 32'hF);
    read_chk("release_edge", 2'd3, 32'h0);

    // Capture and clear in the same cycle: the capture survives
    in_port = 4'hE;
    repeat (5) tick();
    read_chk("coll_pre", 2'd3, 32'h0);
    wr(2'd3, 32'h1);
    read_chk("coll_edge", 2'd3, 32'h1);
    check("coll_irq", 32'(irq), 32'h1);
    wr(2'd3, 32'h1);
    read_chk("coll_clr", 2'd3, 32'h0);

    // Masked capture, then unmask
    wr(2'd2, 32'h0);
    in_port = 4'hA;
    repeat (6) begin
      tick();
      check_regs("masked");
    end
    read_chk("masked_edge", 2'd3, 32'h4);
    check("masked_irq", 32'(irq), 32'h0);
    wr(2'd2, 32'h4);
    check("unmask_irq", 32'(irq), 32'h1);
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hF);
    read_chk("ro_data", 2'd0, 32'hA);
    read_chk("ro_dir",  2'd1, 32'h0);

    // Reset two cycles into a press on bit 3
    in_port = 4'hF;
    repeat (7) tick();
    in_port = 4'h7;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    read_chk("mid_rst_data", 2'd0, 32'hF);
    read_chk("mid_rst_mask", 2'd2, 32'h0);
    read_chk("mid_rst_edge", 2'd3, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) begin
      tick();
      check_regs("redeb");
    end
    read_chk("redeb_pre", 2'd0, 32'hF);
    tick();
    read_chk("redeb_data", 2'd0, 32'h7);
    read_chk("redeb_edge", 2'd3, 32'h8);

    // Randomized inputs and register traffic against the model
    for (int n = 0; n < 400; n++) begin
      tick();
      check_regs("rnd");
      if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bus.address   = 2'($urandom_range(0, 3));
        bus.writedata = $urandom;
        bus.write_n   = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_edge_pio.md
# key_edge_pio

Avalon-MM slave input port for the push-buttons and switches: synchronises `in_port`, debounces each bit, latches qualifying edges into an edge-capture register and raises a maskable level interrupt. It is the input-direction counterpart of the LED output port and sits on the same system interconnect, read by the Nios II driver through the standard PIO register layout.

## Interface

- `WIDTH`, 4: number of input bits.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a bit change is accepted (1 ms at 50 MHz); legal range 1 to 2^20.
- `EDGE_TYPE`, 1: 0 = rising, 1 = falling, 2 = any edge.
- `IDLE_LEVEL`, all ones: reset value of synchroniser and debounced state (keys are active-low).

- `clk`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits above `WIDTH` ignored.
- `readdata`  out  32  read data, zero-extended from `WIDTH`.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `irq`  out  1  level interrupt request.

## Operation

- Register map:
  - 0: data, read-only, debounced value.
  - 1: direction, reads 0, writes ignored.
  - 2: interruptmask, read/write.
  - 3: edgecapture, read; write-1-to-clear per bit.
- Writes to address 0 or 1 have no effect.
- Synchroniser: two flops per bit (`sync1`, `sync2`); no logic between them.
- Debounce, per bit `i`, with `stable[i]` and a counter of width clog2(`DEBOUNCE_CYCLES`+1):
  - `sync2[i] == stable[i]`: counter clears to 0.
  - Mismatch while counter < `DEBOUNCE_CYCLES`-1: counter increments.
  - Mismatch while counter == `DEBOUNCE_CYCLES`-1: `stable[i] <= sync2[i]` and counter clears.
  - Any return to a match before acceptance discards the partial count.
- Edge capture:
  - `edgecapture[i]` sets on the same clock edge that `stable[i]` changes, provided the transition matches `EDGE_TYPE`.
  - It stays set until cleared by software.
  - A write to address 3 with `chipselect=1`, `write_n=0` clears every bit whose `writedata` bit is 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- `irq = |(edgecapture & interruptmask)`, decoded from registers only (glitch-free, no added latency).
- `readdata`: combinational mux of the register selected by `address`, upper bits 0. Reads have no side effects.
- Reset, asynchronous on `reset_n` low, effective immediately including mid-debounce:
  - `sync1`, `sync2`, `stable` <= `IDLE_LEVEL`.
  - All counters <= 0.
  - `interruptmask` <= 0; `edgecapture` <= 0.
  - Resulting outputs: `irq` = 0; `readdata` = `IDLE_LEVEL` at address 0, 0 elsewhere.

## Timing

- Register writes take effect at the clock edge where `chipselect & ~write_n`. The new value is readable and reflected on `irq` in the following cycle.
- Read: zero wait states; `readdata` is valid in the same cycle as `address`/`chipselect`.
- Input latency, for a clean level change on `in_port` sampled at edge k:
  - `sync2` updates at edge k+1.
  - `stable`, `edgecapture` and `irq` update at edge k+1+`DEBOUNCE_CYCLES`.
- Glitch rejection: a change that persists in `sync2` for fewer than `DEBOUNCE_CYCLES` cycles never reaches `stable`.
- With `DEBOUNCE_CYCLES`=1, `stable` follows `sync2` one cycle later.
- Bits are independent: simultaneous changes on several bits are each accepted on their own schedule.

## Test plan

- **Reset values** (`WIDTH`=4, `IDLE_LEVEL`=4'hF), `in_port`=4'hF: read addresses 0..3 -> 0xF, 0, 0, 0; `irq`=0.
- **Press** (`DEBOUNCE_CYCLES`=4, `EDGE_TYPE`=1): write mask 0x1, drive `in_port[0]`=0 at edge k.
  - `stable[0]` and `edgecapture[0]` rise at edge k+5.
  - `irq`=1 from that edge; read address 0 -> 0xE, address 3 -> 0x1.
- **Glitch rejection**: 3-cycle low pulse on bit 1 -> data stays 0xF, `edgecapture`=0, `irq`=0. A subsequent 4+ cycle low is accepted.
- **Clear and collision**:
  - Write 0x1 to address 3 -> `edgecapture`=0, `irq`=0 next cycle.
  - Arrange a new falling acceptance on bit 0 in the same cycle as a clear write -> `edgecapture[0]` remains 1.
- **Edge type and mask**: with `EDGE_TYPE`=1, a release (0->1) sets nothing. With mask=0, a press sets `edgecapture` but `irq` stays 0; then writing mask=1 -> `irq`=1 next cycle.
- **Reset mid-debounce**: pull `reset_n` low 2 cycles into a press.
  - All registers return to reset values immediately.
  - After release, the press still held is re-debounced the full 4 cycles before acceptance.
